// File: rtl/exec_pkg.sv
// exec_pkg -- shared definitions for the exec FIFO entry format and the
// issue-side FSM. The dispatch side packs entries with the same offsets.
package exec_pkg;

   localparam int DATA_W_DEF  = 128;
   localparam int TAG_W_DEF   = 6;
   localparam int OPND_W      = 32;
   localparam int FUNC_W      = 12;

   // Entry field offsets (LSB positions)
   localparam int RS1_DATA_LSB = 0;
   localparam int RS2_DATA_LSB = 32;
   localparam int RS1_TAG_LSB  = 64;
   localparam int RS1_RDY_BIT  = 70;
   localparam int RS2_TAG_LSB  = 71;
   localparam int RS2_RDY_BIT  = 77;
   localparam int RD_TAG_LSB   = 78;
   localparam int FUNC_LSB     = 84;
   localparam int IMM_LSB      = 96;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2
   } issue_state_e;

endpackage

// File: rtl/operand_wakeup.sv
// operand_wakeup -- CDB wake-up for one source operand.
// Ports:
//   src_data/src_tag/src_rdy : operand as currently known (held or popped)
//   cdb_valid/cdb_tag/cdb_data : common data bus broadcast
//   nxt_data/nxt_rdy         : operand after applying this cycle's broadcast
// An operand that is already ready ignores the bus even on a tag match.
module operand_wakeup
   import exec_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic [OPND_W-1:0] src_data,
   input  logic [TAG_W-1:0]  src_tag,
   input  logic              src_rdy,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [OPND_W-1:0] cdb_data,
   output logic [OPND_W-1:0] nxt_data,
   output logic              nxt_rdy
);

   logic hit;

   assign hit      = cdb_valid && !src_rdy && (cdb_tag == src_tag);
   assign nxt_data = hit ? cdb_data : src_data;
   assign nxt_rdy  = src_rdy | hit;

endmodule

// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl -- single-entry issue stage between the exec FIFO and a
// functional unit. Pops one entry, waits for its operands on the CDB, then
// presents it to the FU until accepted.
// Ports:
//   i_clk, i_rst             : clock, async active-high reset
//   fifo_empty/fifo_data     : FIFO head (data valid only while fifo_rd_en=1)
//   fifo_rd_en               : FIFO pop strobe
//   flush                    : discard held entry, block pops this cycle
//   cdb_valid/cdb_tag/cdb_data : result broadcast for operand wake-up
//   fu_ready                 : FU accepts an op this cycle
//   issue_*                  : op presented to the FU, valid in READY only
module exec_issue_ctrl
   import exec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_W_DEF,
   parameter int TAG_W      = TAG_W_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   input  logic                  flush,
   input  logic                  cdb_valid,
   input  logic [TAG_W-1:0]      cdb_tag,
   input  logic [31:0]           cdb_data,
   input  logic                  fu_ready,
   output logic                  issue_valid,
   output logic [31:0]           issue_rs1,
   output logic [31:0]           issue_rs2,
   output logic [31:0]           issue_imm,
   output logic [11:0]           issue_func,
   output logic [TAG_W-1:0]      issue_rd_tag
);

   issue_state_e        state_q, state_d;
   logic [OPND_W-1:0]   rs1_data_q, rs1_data_d;
   logic [OPND_W-1:0]   rs2_data_q, rs2_data_d;
   logic [TAG_W-1:0]    rs1_tag_q, rs1_tag_d;
   logic [TAG_W-1:0]    rs2_tag_q, rs2_tag_d;
   logic                rs1_rdy_q, rs1_rdy_d;
   logic                rs2_rdy_q, rs2_rdy_d;
   logic [TAG_W-1:0]    rd_tag_q, rd_tag_d;
   logic [FUNC_W-1:0]   func_q, func_d;
   logic [OPND_W-1:0]   imm_q, imm_d;

   logic                pop;

   // Operand source: the FIFO head when popping, otherwise the held entry.
   // Running the popped operands through wake-up gives same-cycle bypass.
   logic [OPND_W-1:0]   src1_data, src2_data;
   logic [TAG_W-1:0]    src1_tag, src2_tag;
   logic                src1_rdy, src2_rdy;
   logic [OPND_W-1:0]   w1_data, w2_data;
   logic                w1_rdy, w2_rdy;

   // Reset gates the pop so a non-empty FIFO is never drained during reset.
   assign pop = !i_rst && !fifo_empty && !flush &&
                ((state_q == ST_EMPTY) || ((state_q == ST_READY) && fu_ready));

   assign src1_data = pop ? fifo_data[RS1_DATA_LSB +: OPND_W] : rs1_data_q;
   assign src2_data = pop ? fifo_data[RS2_DATA_LSB +: OPND_W] : rs2_data_q;
   assign src1_tag  = pop ? fifo_data[RS1_TAG_LSB +: TAG_W]   : rs1_tag_q;
   assign src2_tag  = pop ? fifo_data[RS2_TAG_LSB +: TAG_W]   : rs2_tag_q;
   assign src1_rdy  = pop ? fifo_data[RS1_RDY_BIT]            : rs1_rdy_q;
   assign src2_rdy  = pop ? fifo_data[RS2_RDY_BIT]            : rs2_rdy_q;

   operand_wakeup #(.TAG_W(TAG_W)) u_wake_rs1 (
      .src_data  (src1_data),
      .src_tag   (src1_tag),
      .src_rdy   (src1_rdy),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt_data  (w1_data),
      .nxt_rdy   (w1_rdy)
   );

   operand_wakeup #(.TAG_W(TAG_W)) u_wake_rs2 (
      .src_data  (src2_data),
      .src_tag   (src2_tag),
      .src_rdy   (src2_rdy),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .nxt_data  (w2_data),
      .nxt_rdy   (w2_rdy)
   );

   always_comb begin
      state_d    = state_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      rs1_tag_d  = rs1_tag_q;
      rs2_tag_d  = rs2_tag_q;
      rs1_rdy_d  = rs1_rdy_q;
      rs2_rdy_d  = rs2_rdy_q;
      rd_tag_d   = rd_tag_q;
      func_d     = func_q;
      imm_d      = imm_q;

      if (flush) begin
         state_d    = ST_EMPTY;
         rs1_data_d = '0;
         rs2_data_d = '0;
         rs1_tag_d  = '0;
         rs2_tag_d  = '0;
         rs1_rdy_d  = 1'b0;
         rs2_rdy_d  = 1'b0;
         rd_tag_d   = '0;
         func_d     = '0;
         imm_d      = '0;
      end else if (pop) begin
         rs1_data_d = w1_data;
         rs2_data_d = w2_data;
         rs1_tag_d  = src1_tag;
         rs2_tag_d  = src2_tag;
         rs1_rdy_d  = w1_rdy;
         rs2_rdy_d  = w2_rdy;
         rd_tag_d   = fifo_data[RD_TAG_LSB +: TAG_W];
         func_d     = fifo_data[FUNC_LSB +: FUNC_W];
         imm_d      = fifo_data[IMM_LSB +: OPND_W];
         state_d    = (w1_rdy && w2_rdy) ? ST_READY : ST_WAIT;
      end else begin
         case (state_q)
            ST_WAIT: begin
               rs1_data_d = w1_data;
               rs2_data_d = w2_data;
               rs1_rdy_d  = w1_rdy;
               rs2_rdy_d  = w2_rdy;
               if (w1_rdy && w2_rdy) state_d = ST_READY;
            end
            ST_READY: begin
               // Accepted with nothing to refill: entry leaves, stale data
               // stays in the register but issue_valid drops.
               if (fu_ready) state_d = ST_EMPTY;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_EMPTY;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         rs1_tag_q  <= '0;
         rs2_tag_q  <= '0;
         rs1_rdy_q  <= 1'b0;
         rs2_rdy_q  <= 1'b0;
         rd_tag_q   <= '0;
         func_q     <= '0;
         imm_q      <= '0;
      end else begin
         state_q    <= state_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rs1_tag_q  <= rs1_tag_d;
         rs2_tag_q  <= rs2_tag_d;
         rs1_rdy_q  <= rs1_rdy_d;
         rs2_rdy_q  <= rs2_rdy_d;
         rd_tag_q   <= rd_tag_d;
         func_q     <= func_d;
         imm_q      <= imm_d;
      end
   end

   assign fifo_rd_en   = pop;
   assign issue_valid  = (state_q == ST_READY);
   assign issue_rs1    = rs1_data_q;
   assign issue_rs2    = rs2_data_q;
   assign issue_imm    = imm_q;
   assign issue_func   = func_q;
   assign issue_rd_tag = rd_tag_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
module tb_exec_issue_ctrl;

   localparam int DW = 128;
   localparam int TW = 6;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          fifo_empty;
   logic [DW-1:0] fifo_data;
   logic          fifo_rd_en;
   logic          flush;
   logic          cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic [31:0]   cdb_data;
   logic          fu_ready;
   logic          issue_valid;
   logic [31:0]   issue_rs1, issue_rs2, issue_imm;
   logic [11:0]   issue_func;
   logic [TW-1:0] issue_rd_tag;

   exec_issue_ctrl #(.DATA_WIDTH(DW), .TAG_W(TW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
      .flush(flush),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .fu_ready(fu_ready),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_imm(issue_imm), .issue_func(issue_func), .issue_rd_tag(issue_rd_tag)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [31:0]   rs1;
      logic [31:0]   rs2;
      logic [31:0]   imm;
      logic [11:0]   func;
      logic [TW-1:0] rd;
   } exp_t;

   logic [DW-1:0] fq[$];
   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   int            pushes = 0;
   int            pops   = 0;
   logic          rd_seen;

   function automatic logic [DW-1:0] mk(input logic [31:0] rs1, input logic [31:0] rs2,
                                        input logic [5:0] t1, input logic r1,
                                        input logic [5:0] t2, input logic r2,
                                        input logic [5:0] rd, input logic [11:0] fn,
                                        input logic [31:0] imm);
      return {imm, fn, rd, r2, t2, r1, t1, rs2, rs1};
   endfunction

   function automatic void refresh();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() == 0) ? '0 : fq[0];
   endfunction

   // Push an entry into the FIFO model and record what it should issue as.
   task automatic push(input logic [DW-1:0] e, input logic [31:0] x1, input logic [31:0] x2);
      exp_t x;
      fq.push_back(e);
      x.rs1  = x1;
      x.rs2  = x2;
      x.imm  = e[127:96];
      x.func = e[95:84];
      x.rd   = e[83:78];
      exp_q.push_back(x);
      pushes++;
      refresh();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   // FIFO model: the pop strobe is sampled at the edge, head advances after.
   always @(posedge i_clk) begin
      rd_seen = fifo_rd_en;
      #1;
      if (rd_seen === 1'b1) begin
         if (fq.size() > 0) begin
            fq.delete(0);
            pops++;
         end
      end
      refresh();
   end

   // Scoreboard: every transfer must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      if (i_rst === 1'b0 && issue_valid === 1'b1 && fu_ready === 1'b1) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_issue observed=imm %0h expected=none", issue_imm);
         end
         if (exp_q.size() > 0) begin
            checks++;
            assert ({issue_rs1, issue_rs2, issue_imm, issue_func, issue_rd_tag} === exp_q[0]) else begin
               errors++;
               $error("FAIL issue_data observed=%0h/%0h/%0h/%0h/%0h expected=%0h/%0h/%0h/%0h/%0h",
                      issue_rs1, issue_rs2, issue_imm, issue_func, issue_rd_tag,
                      exp_q[0].rs1, exp_q[0].rs2, exp_q[0].imm, exp_q[0].func, exp_q[0].rd);
            end
            exp_q.delete(0);
         end
      end
   end

   logic [DW-1:0] ef, eg;

   initial begin
      i_rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
      fu_ready = 1'b1;
      refresh();
      tick(); tick();

      // Reset with a non-empty FIFO, then a fully ready entry issues.
      push(mk(32'h11111111, 32'h22222222, 6'd1, 1'b1, 6'd2, 1'b1, 6'd7, 12'h0A5, 32'hA0A0A0A0),
           32'h11111111, 32'h22222222);
      #1;
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_valid", issue_valid, 0);
      chk("rst_imm", issue_imm, 0);
      chk("rst_rs1", issue_rs1, 0);
      i_rst = 1'b0;
      #1;
      chk("pop_a_rd_en", fifo_rd_en, 1);
      chk("pop_a_valid", issue_valid, 0);
      tick(); #1;
      chk("a_valid", issue_valid, 1);
      chk("a_rd_en_after", fifo_rd_en, 0);
      tick(); #1;
      chk("a_done", issue_valid, 0);

      // rs1 waits on tag 5; an unrelated broadcast must not wake it.
      push(mk(32'h0, 32'h33333333, 6'd5, 1'b0, 6'd4, 1'b1, 6'd8, 12'h123, 32'h0B0B0B0B),
           32'hDEADBEEF, 32'h33333333);
      tick(); #1;
      chk("b_wait", issue_valid, 0);
      cdb_valid = 1'b1; cdb_tag = 6'd6; cdb_data = 32'h55555555;
      tick(); #1;
      cdb_valid = 1'b0;
      chk("b_no_wake", issue_valid, 0);
      tick();
      cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'hDEADBEEF;
      #1;
      chk("b_still_wait", issue_valid, 0);
      tick();
      cdb_valid = 1'b0; #1;
      chk("b_valid", issue_valid, 1);
      chk("b_rs1", issue_rs1, 32'hDEADBEEF);
      tick();

      // Same-cycle bypass on pop; ready rs1 shares tag 9 and must be untouched.
      push(mk(32'h44444444, 32'h0, 6'd9, 1'b1, 6'd9, 1'b0, 6'd10, 12'hABC, 32'h0C0C0C0C),
           32'h44444444, 32'h12345678);
      cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h12345678;
      #1;
      chk("c_pop", fifo_rd_en, 1);
      tick();
      cdb_valid = 1'b0; #1;
      chk("c_ready_no_wait", issue_valid, 1);
      chk("c_rs2", issue_rs2, 32'h12345678);
      chk("c_rs1_kept", issue_rs1, 32'h44444444);
      tick();

      // Both operands on one tag wake from a single broadcast.
      push(mk(32'h0, 32'h0, 6'd12, 1'b0, 6'd12, 1'b0, 6'd11, 12'h00F, 32'h0D0D0D0D),
           32'hCAFEF00D, 32'hCAFEF00D);
      tick(); #1;
      chk("d_wait", issue_valid, 0);
      cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hCAFEF00D;
      tick();
      cdb_valid = 1'b0; #1;
      chk("d_valid", issue_valid, 1);
      tick();

      // Back-to-back: four ready entries, one pop and one issue per cycle.
      for (int i = 0; i < 4; i++) begin
         push(mk(32'h100 + i, 32'h200 + i, 6'd1, 1'b1, 6'd2, 1'b1, 6'(20 + i), 12'(i), 32'h300 + i),
              32'h100 + i, 32'h200 + i);
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("b2b_rd_en", fifo_rd_en, 1);
         tick(); #1;
         chk("b2b_valid", issue_valid, 1);
         chk("b2b_imm", issue_imm, 32'h300 + i);
      end
      chk("b2b_drained", fifo_rd_en, 0);
      tick(); #1;
      chk("b2b_done", issue_valid, 0);

      // Stall five cycles with a second entry waiting, then flush.
      fu_ready = 1'b0;
      ef = mk(32'h66666666, 32'h77777777, 6'd1, 1'b1, 6'd2, 1'b1, 6'd30, 12'hF0F, 32'hEEEE0001);
      eg = mk(32'h88888888, 32'h99999999, 6'd1, 1'b1, 6'd2, 1'b1, 6'd31, 12'h0F0, 32'hEEEE0002);
      push(ef, 32'h66666666, 32'h77777777);
      push(eg, 32'h88888888, 32'h99999999);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_rd_en", fifo_rd_en, 0);
         chk("stall_valid", issue_valid, 1);
         chk("stall_imm", issue_imm, 32'hEEEE0001);
         chk("stall_rs1", issue_rs1, 32'h66666666);
         tick();
      end
      flush = 1'b1;
      exp_q.delete(0);
      #1;
      chk("flush_rd_en", fifo_rd_en, 0);
      tick();
      flush = 1'b0; #1;
      chk("flush_valid", issue_valid, 0);
      fu_ready = 1'b1;
      tick(); #1;
      chk("g_valid", issue_valid, 1);
      chk("g_imm", issue_imm, 32'hEEEE0002);
      tick();

      // Reset in the middle of WAIT drops the entry.
      push(mk(32'h0, 32'hABABABAB, 6'd3, 1'b0, 6'd2, 1'b1, 6'd13, 12'h555, 32'h0E0E0E0E),
           32'h0, 32'h0);
      tick(); #1;
      chk("h_wait", issue_valid, 0);
      tick();
      i_rst = 1'b1;
      cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h13579BDF;
      exp_q.delete(0);
      #1;
      chk("mid_rst_valid", issue_valid, 0);
      chk("mid_rst_rd_en", fifo_rd_en, 0);
      chk("mid_rst_rs1", issue_rs1, 0);
      chk("mid_rst_rs2", issue_rs2, 0);
      chk("mid_rst_rd_tag", issue_rd_tag, 0);
      chk("mid_rst_func", issue_func, 0);
      tick(); #1;
      chk("mid_rst_hold", issue_valid, 0);
      i_rst = 1'b0; cdb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("post_rst_idle", issue_valid, 0);
      end

      chk("exp_drained", exp_q.size(), 0);
      chk("pops_eq_pushes", pops, pushes);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exec_issue_ctrl.md
EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, exec FIFO entry width.
REQ-002 SHALL have parameter TAG_W, default 6, physical register tag width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports fifo_empty (input, 1) and fifo_data (input, DATA_WIDTH), the exec FIFO empty flag and head entry.
REQ-006 SHALL have port fifo_rd_en, output, 1, the exec FIFO pop strobe.
REQ-007 SHALL have port flush, input, 1, pipeline flush.
REQ-008 SHALL have ports cdb_valid (input, 1), cdb_tag (input, TAG_W) and cdb_data (input, 32), the common data bus broadcast.
REQ-009 SHALL have port fu_ready, input, 1, functional unit accepts an op this cycle.
REQ-010 SHALL have ports issue_valid (output, 1), issue_rs1 (output, 32), issue_rs2 (output, 32), issue_imm (output, 32), issue_func (output, 12) and issue_rd_tag (output, TAG_W).

Function
REQ-011 SHALL decode each entry as: [31:0] rs1_data, [63:32] rs2_data, [69:64] rs1_tag, [70] rs1_rdy, [76:71] rs2_tag, [77] rs2_rdy, [83:78] rd_tag, [95:84] func, [127:96] imm.
REQ-012 SHALL capture fifo_data in the same cycle fifo_rd_en is high, because FIFO read data is combinational and valid only while fifo_rd_en is asserted.
REQ-013 SHALL hold at most one entry in an internal holding register.
REQ-014 SHALL implement FSM states EMPTY, WAIT and READY.
- EMPTY: no entry held.
- WAIT: entry held, at least one operand not ready.
- READY: both operands ready, issue_valid=1.
REQ-015 SHALL assert fifo_rd_en when fifo_empty=0 and flush=0 and one of the following holds:
- state is EMPTY;
- state is READY and fu_ready=1 (back-to-back pop).
REQ-016 SHALL, on pop, go to READY if both operands are ready after CDB bypass, otherwise go to WAIT.
REQ-017 SHALL, in READY with fu_ready=1 and no pop, go to EMPTY.
REQ-018 SHALL, in READY with fu_ready=0, hold the entry and keep issue outputs stable.
REQ-019 SHALL, for each not-ready operand, load cdb_data and set its ready bit when cdb_valid=1 and cdb_tag equals the operand tag.
REQ-020 SHALL apply the REQ-019 match both to the held entry and to an entry being popped in the same cycle (same-cycle bypass).
REQ-021 SHALL allow a single CDB broadcast to wake both operands when rs1_tag equals rs2_tag.
REQ-022 SHALL leave an already-ready operand unchanged by a matching CDB broadcast.
REQ-023 SHALL have issue latency of exactly one cycle from the last operand becoming ready to issue_valid=1.
REQ-024 SHALL drive issue_valid=1 only in READY; a transfer occurs on the cycle issue_valid and fu_ready are both 1.
REQ-025 SHALL give flush priority over pop, wake-up and issue: next state EMPTY, holding register cleared, fifo_rd_en=0 during the flush cycle.
REQ-026 SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-027 SHALL, when a popped entry is already fully ready and fu_ready=1 in READY, sustain one issue per cycle.

Reset
REQ-028 SHALL, while i_rst=1, force state EMPTY and clear the holding register to 0, independent of i_clk.
REQ-029 SHALL hold fifo_rd_en, issue_valid and all issue_* data outputs at 0 during reset.
REQ-030 SHALL discard any held entry without issuing it when reset is asserted mid-operation.

Structure
REQ-031 SHALL take the entry field offsets, TAG_W default, and the FSM state enum from a shared package exec_pkg, also used by the dispatch side.
REQ-032 SHALL implement the operand wake-up (tag compare plus data/ready mux) as one sub-module, operand_wakeup, instantiated twice (rs1, rs2).

Verification
REQ-033 SHALL cover: entry with both operands ready, fu_ready=1 -> fifo_rd_en for one cycle, issue_valid next cycle with the entry's rs1/rs2/imm/func/rd_tag.
REQ-034 SHALL cover: rs1_rdy=0, rs1_tag=5; three cycles later cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF -> issue_valid one cycle later with issue_rs1=0xDEADBEEF.
REQ-035 SHALL cover: pop in the same cycle as cdb_tag matching rs2_tag=9 -> rs2 captured, state READY, no WAIT cycle.
REQ-036 SHALL cover: four ready entries queued, fu_ready held 1 -> four consecutive issue cycles, fifo_rd_en high four consecutive cycles.
REQ-037 SHALL cover: state READY, fu_ready=0 for five cycles -> outputs stable and no pop; then flush=1 -> issue_valid=0 next cycle and no later issue of that entry.
REQ-038 SHALL cover: i_rst pulsed mid-WAIT -> all outputs 0 immediately, state EMPTY, no spurious issue after release.
